// File: rtl/ofdm_pkg.sv
// ofdm_pkg: code-rate encodings, puncture masks/periods and defaults for the OFDM puncturing unit
package ofdm_pkg;
    localparam int RATE_1_2   = 0;
    localparam int RATE_2_3   = 1;
    localparam int RATE_3_4   = 2;
    localparam int N_CBPS_DEF = 384;
    localparam int PHASE_W    = 3;

    // Bit i of a mask is the keep flag for puncture phase i
    localparam logic [7:0] MASK_1_2 = 8'b0000_0011;
    localparam logic [7:0] MASK_2_3 = 8'b0000_0111;
    localparam logic [7:0] MASK_3_4 = 8'b0010_0111;

    localparam int PERIOD_1_2 = 2;
    localparam int PERIOD_2_3 = 4;
    localparam int PERIOD_3_4 = 6;

    function automatic logic [7:0] rate_mask(input int rate);
        return rate == RATE_3_4 ? MASK_3_4 : rate == RATE_2_3 ? MASK_2_3 : MASK_1_2;
    endfunction

    function automatic int rate_period(input int rate);
        return rate == RATE_3_4 ? PERIOD_3_4 : rate == RATE_2_3 ? PERIOD_2_3 : PERIOD_1_2;
    endfunction
endpackage

// File: rtl/ppu_sym_cnt.sv
// ppu_sym_cnt: counts kept bits and registers the OFDM symbol index of each emitted bit
module ppu_sym_cnt
    import ofdm_pkg::*;
#(
    parameter int N_CBPS = N_CBPS_DEF,
    parameter int SYM_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             keep,
    output logic [SYM_W-1:0] do_sym_num
);
    localparam logic [11:0] LAST = 12'(N_CBPS - 1);

    logic [11:0]      bit_cnt;
    logic [SYM_W-1:0] sym_cur;

    // do_sym_num captures the index the bit belonged to; sym_cur already points at the next bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            sym_cur    <= '0;
            do_sym_num <= '0;
        end else if (keep) begin
            do_sym_num <= sym_cur;
            bit_cnt    <= bit_cnt == LAST ? 12'd0 : bit_cnt + 12'd1;
            sym_cur    <= bit_cnt == LAST ? sym_cur + 1'b1 : sym_cur;
        end
    end
endmodule

// File: rtl/ofdm_ppu.sv
// ofdm_ppu: bit-serial puncturer for the rate-1/2 A/B coded stream, tagging each surviving bit with its symbol index
// dout carries the punctured bit; "do" is a reserved word in SystemVerilog
module ofdm_ppu
    import ofdm_pkg::*;
#(
    parameter int RATE   = RATE_3_4,
    parameter int N_CBPS = N_CBPS_DEF,
    parameter int SYM_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di,
    input  logic             di_vld,
    output logic             dout,
    output logic             do_vld,
    output logic [SYM_W-1:0] do_sym_num
);
    localparam logic [7:0]         MASK = rate_mask(RATE);
    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(rate_period(RATE) - 1);

    logic [PHASE_W-1:0] ph;
    logic               keep;

    assign keep = di_vld & MASK[ph];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph     <= '0;
            dout   <= 1'b0;
            do_vld <= 1'b0;
        end else begin
            ph     <= di_vld ? (ph == LAST ? '0 : ph + 1'b1) : ph;
            dout   <= keep ? di : dout;
            do_vld <= keep;
        end
    end

    ppu_sym_cnt #(.N_CBPS(N_CBPS), .SYM_W(SYM_W)) u_sym_cnt (
        .clk(clk),
        .rst(rst),
        .keep(keep),
        .do_sym_num(do_sym_num)
    );
endmodule

// File: tb/tb_ofdm_ppu.sv
// tb_ofdm_ppu: directed tests of the puncturer at rate 3/4, 2/3 and 1/2 with a short symbol
module tb_ofdm_ppu;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       di = 1'b0;
    logic       di_vld = 1'b0;
    logic       u2_do, u2_vld, u1_do, u1_vld, u0_do, u0_vld;
    logic [3:0] u2_sym, u1_sym, u0_sym;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    ofdm_ppu #(.RATE(2), .N_CBPS(384), .SYM_W(4)) u2 (
        .clk(clk), .rst(rst), .di(di), .di_vld(di_vld),
        .dout(u2_do), .do_vld(u2_vld), .do_sym_num(u2_sym)
    );
    ofdm_ppu #(.RATE(1), .N_CBPS(384), .SYM_W(4)) u1 (
        .clk(clk), .rst(rst), .di(di), .di_vld(di_vld),
        .dout(u1_do), .do_vld(u1_vld), .do_sym_num(u1_sym)
    );
    ofdm_ppu #(.RATE(0), .N_CBPS(4), .SYM_W(4)) u0 (
        .clk(clk), .rst(rst), .di(di), .di_vld(di_vld),
        .dout(u0_do), .do_vld(u0_vld), .do_sym_num(u0_sym)
    );

    task automatic step(input logic b, input logic v);
        di = b;
        di_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        di_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({u2_do, u2_vld, u2_sym} !== 6'd0) begin
            fails++;
            $display("FAIL reset_u2 got %b want 000000", {u2_do, u2_vld, u2_sym});
        end
        tests++;
        if ({u1_do, u1_vld, u1_sym} !== 6'd0) begin
            fails++;
            $display("FAIL reset_u1 got %b want 000000", {u1_do, u1_vld, u1_sym});
        end
        tests++;
        if ({u0_do, u0_vld, u0_sym} !== 6'd0) begin
            fails++;
            $display("FAIL reset_u0 got %b want 000000", {u0_do, u0_vld, u0_sym});
        end
        rst = 1'b1;
    endtask

    task automatic test_frame;
        int   pulses = 0;
        int   errs = 0;
        logic b, kp;
        do_reset();
        for (int k = 0; k < 8640; k++) begin
            b = 1'($urandom_range(0, 1));
            kp = (k % 6) inside {0, 1, 2, 5};
            step(b, 1'b1);
            if (k == 0) begin
                tests++;
                if (u2_vld !== 1'b1) begin
                    fails++;
                    $display("FAIL frame_first_out do_vld=%b want 1", u2_vld);
                end
            end
            if (u2_vld !== kp) errs++;
            if (kp && (u2_do !== b || u2_sym !== 4'(pulses / 384))) errs++;
            if (u2_vld === 1'b1) pulses++;
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL frame_data errors=%0d want 0", errs);
        end
        tests++;
        if (pulses != 5760) begin
            fails++;
            $display("FAIL frame_count pulses=%0d want 5760", pulses);
        end
        tests++;
        if (u2_sym !== 4'd14) begin
            fails++;
            $display("FAIL frame_last_sym got %0d want 14", u2_sym);
        end
    endtask

    task automatic test_pattern;
        logic ev [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic ed [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(k % 2 == 0, 1'b1);
            tests++;
            if (u2_vld !== ev[k % 6]) begin
                fails++;
                $display("FAIL pattern_vld k=%0d got %b want %b", k, u2_vld, ev[k % 6]);
            end
            tests++;
            if (u2_do !== ed[k % 6]) begin
                fails++;
                $display("FAIL pattern_do k=%0d got %b want %b", k, u2_do, ed[k % 6]);
            end
        end
    endtask

    task automatic test_rate;
        logic [11:0] in_bits = 12'b0111_0011_1001;
        logic [8:0]  got = '0;
        int          n = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(in_bits[11 - k], 1'b1);
            if (u1_vld === 1'b1) begin
                got = {got[7:0], u1_do};
                n++;
            end
        end
        tests++;
        if (n != 9) begin
            fails++;
            $display("FAIL rate_count got %0d want 9", n);
        end
        tests++;
        if (got !== 9'b011001100) begin
            fails++;
            $display("FAIL rate_bits got %b want 011001100", got);
        end
    endtask

    task automatic test_wrap;
        int   errs = 0;
        logic b;
        do_reset();
        for (int k = 0; k < 72; k++) begin
            b = 1'($urandom_range(0, 1));
            step(b, 1'b1);
            if (u0_vld !== 1'b1 || u0_do !== b || u0_sym !== 4'((k / 4) % 16)) errs++;
            if (k == 63) begin
                tests++;
                if (u0_sym !== 4'd15) begin
                    fails++;
                    $display("FAIL wrap_sym15 got %0d want 15", u0_sym);
                end
            end
            if (k == 64) begin
                tests++;
                if (u0_sym !== 4'd0) begin
                    fails++;
                    $display("FAIL wrap_sym0 got %0d want 0", u0_sym);
                end
            end
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL wrap_passthru errors=%0d want 0", errs);
        end
    endtask

    task automatic test_gaps;
        logic [23:0] v = 24'($urandom);
        logic        q1 [$];
        logic        q2 [$];
        int          errs = 0;
        int          idle;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            step(v[k], 1'b1);
            if (u2_vld === 1'b1) q1.push_back(u2_do);
        end
        do_reset();
        for (int k = 0; k < 24; k++) begin
            idle = $urandom_range(0, 3);
            for (int j = 0; j < idle; j++) begin
                step(1'($urandom_range(0, 1)), 1'b0);
                if (u2_vld !== 1'b0) errs++;
            end
            step(v[k], 1'b1);
            if (u2_vld === 1'b1) q2.push_back(u2_do);
        end
        tests++;
        if (q1.size() != 16 || q2.size() != 16) begin
            fails++;
            $display("FAIL gaps_count got %0d/%0d want 16/16", q1.size(), q2.size());
        end
        for (int i = 0; i < 16 && i < q1.size() && i < q2.size(); i++)
            if (q1[i] !== q2[i] || q1[i] !== v[(i / 4) * 6 + (i % 4 == 3 ? 5 : i % 4)]) errs++;
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL gaps_seq errors=%0d want 0", errs);
        end
    endtask

    task automatic test_async_reset;
        logic ev [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int   errs = 0;
        do_reset();
        for (int k = 0; k < 9; k++) step(1'b1, 1'b1);
        tests++;
        if (u0_sym !== 4'd2 || u2_vld !== 1'b1 || u2_do !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre got sym=%0d vld=%b do=%b want 2 1 1", u0_sym, u2_vld, u2_do);
        end
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if ({u2_do, u2_vld, u2_sym, u0_vld, u0_sym} !== 11'd0) begin
            fails++;
            $display("FAIL areset_now got %b want 0", {u2_do, u2_vld, u2_sym, u0_vld, u0_sym});
        end
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(k % 2 == 0, 1'b1);
            if (u2_vld !== ev[k] || u2_sym !== 4'd0 || u0_sym !== 4'(k / 4)) errs++;
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL areset_restart errors=%0d want 0", errs);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pattern();
        test_rate();
        test_wrap();
        test_gaps();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
